ir_key_ctrl: RTL and testbench

IR_KEY_CTRL -- requirements
Module: ir_key_ctrl

---
 rtl/ir_pkg.sv | 32 +++
 rtl/capture_handshake.sv | 38 +++
 rtl/ir_key_ctrl.sv | 107 ++++++++++
 tb/tb_ir_key_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared key map, capture FSM encoding and brightness helpers for the IR key controller.
package ir_pkg;

  localparam logic [7:0] KEY_BRIGHT_UP  = 8'h1A;
  localparam logic [7:0] KEY_BRIGHT_DN  = 8'h1E;
  localparam logic [7:0] KEY_MODE       = 8'h12;
  localparam logic [7:0] KEY_FREEZE     = 8'h16;
  localparam logic [7:0] KEY_CAPTURE    = 8'h0F;
  localparam logic [7:0] KEY_DEFAULTS   = 8'h00;

  localparam logic [7:0] BRIGHT_DEFAULT = 8'd128;
  localparam logic [1:0] MODE_LAST      = 2'd2;

  typedef enum logic [1:0] {
    C_IDLE     = 2'd0,
    C_REQ      = 2'd1,
    C_WAIT_LOW = 2'd2
  } cap_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] step);
    logic [9:0] sum;
    sum = {2'b00, a} + {1'b0, step};
    return (sum > 10'd255) ? 8'd255 : sum[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [8:0] step);
    logic [8:0] diff;
    diff = {1'b0, a} - step;
    return ({1'b0, a} < step) ? 8'd0 : diff[7:0];
  endfunction

endpackage

// File: rtl/capture_handshake.sv
// Four-phase capture request: req rises on start, drops on ack, and the FSM waits for ack low.
// req is a registered level; start is ignored unless idle (busy tells the caller).
module capture_handshake
  import ir_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic busy
);

  cap_state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= C_IDLE;
      req   <= 1'b0;
    end else begin
      state <= state_nxt;
      req   <= (state_nxt == C_REQ);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:     if (start) state_nxt = C_REQ;
      C_REQ:      if (ack)   state_nxt = C_WAIT_LOW;
      C_WAIT_LOW: if (!ack)  state_nxt = C_IDLE;
      default:    state_nxt = C_IDLE;
    endcase
  end

  assign busy = (state != C_IDLE);

endmodule

// File: rtl/ir_key_ctrl.sv
// IR remote key decoder to display settings: 1-cycle latency from key_valid to update/pulse.
// No backpressure; a repeated key within the lockout window is silently ignored.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 10_000_000,
  parameter int unsigned BRIGHT_STEP    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       capture_ack,
  output logic [7:0] brightness,
  output logic [1:0] mode,
  output logic       freeze,
  output logic       capture_req,
  output logic       cmd_done,
  output logic       cmd_drop
);

  localparam logic [23:0] LOCKOUT_LOAD = 24'(LOCKOUT_CYCLES);
  localparam logic [8:0]  STEP         = 9'(BRIGHT_STEP);

  logic [23:0] lockout_cnt;
  logic [7:0]  last_key;
  logic        accept;
  logic        cap_busy;
  logic        cap_start;
  logic [7:0]  bright_nxt;
  logic [1:0]  mode_nxt;
  logic        freeze_nxt;
  logic        done_nxt;
  logic        drop_nxt;

  // Held keys reload the lockout on every repeat, so they never retrigger.
  assign accept = key_valid && ((lockout_cnt == 24'd0) || (key_code != last_key));

  always_comb begin
    bright_nxt = brightness;
    mode_nxt   = mode;
    freeze_nxt = freeze;
    done_nxt   = 1'b0;
    drop_nxt   = 1'b0;
    cap_start  = 1'b0;
    if (accept) begin
      done_nxt = 1'b1;
      case (key_code)
        KEY_BRIGHT_UP: bright_nxt = sat_add(brightness, STEP);
        KEY_BRIGHT_DN: bright_nxt = sat_sub(brightness, STEP);
        KEY_MODE:      mode_nxt   = (mode >= MODE_LAST) ? 2'd0 : mode + 2'd1;
        KEY_FREEZE:    freeze_nxt = !freeze;
        KEY_DEFAULTS: begin
          bright_nxt = BRIGHT_DEFAULT;
          mode_nxt   = 2'd0;
          freeze_nxt = 1'b0;
        end
        KEY_CAPTURE: begin
          if (cap_busy) begin
            done_nxt = 1'b0;
            drop_nxt = 1'b1;
          end else begin
            cap_start = 1'b1;
          end
        end
        default: begin
          done_nxt = 1'b0;
          drop_nxt = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockout_cnt <= 24'd0;
      last_key    <= 8'h00;
      brightness  <= BRIGHT_DEFAULT;
      mode        <= 2'd0;
      freeze      <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_drop    <= 1'b0;
    end else begin
      if (key_valid) begin
        lockout_cnt <= LOCKOUT_LOAD;
        last_key    <= key_code;
      end else if (lockout_cnt != 24'd0) begin
        lockout_cnt <= lockout_cnt - 24'd1;
      end
      brightness <= bright_nxt;
      mode       <= mode_nxt;
      freeze     <= freeze_nxt;
      cmd_done   <= done_nxt;
      cmd_drop   <= drop_nxt;
    end
  end

  capture_handshake u_capture (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cap_start),
    .ack   (capture_ack),
    .req   (capture_req),
    .busy  (cap_busy)
  );

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl with a short lockout: key table, saturation, lockout, capture and reset.
module tb_ir_key_ctrl;
  import ir_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       capture_ack;
  logic [7:0] brightness;
  logic [1:0] mode;
  logic       freeze;
  logic       capture_req;
  logic       cmd_done;
  logic       cmd_drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic [7:0] bright;
    logic [1:0] mode;
    logic       frz;
    logic       done;
    logic       drop;
  } vec_t;

  vec_t vecs[13];

  ir_key_ctrl #(.LOCKOUT_CYCLES(100), .BRIGHT_STEP(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .capture_ack (capture_ack),
    .brightness  (brightness),
    .mode        (mode),
    .freeze      (freeze),
    .capture_req (capture_req),
    .cmd_done    (cmd_done),
    .cmd_drop    (cmd_drop)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Key is sampled on the following edge; returns 1 ns after that edge.
  task automatic pulse(input logic [7:0] code);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bright"}, brightness, 128);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_freeze"}, freeze, 0);
    check({tag, "_req"}, capture_req, 0);
    check({tag, "_done"}, cmd_done, 0);
    check({tag, "_drop"}, cmd_drop, 0);
  endtask

  initial begin
    vecs[0]  = '{KEY_BRIGHT_UP, 8'd136, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{KEY_BRIGHT_UP, 8'd144, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{KEY_BRIGHT_UP, 8'd152, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{KEY_BRIGHT_DN, 8'd144, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{KEY_MODE,      8'd144, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{KEY_FREEZE,    8'd144, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{8'h55,         8'd144, 2'd1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{KEY_MODE,      8'd144, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{KEY_MODE,      8'd144, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{KEY_FREEZE,    8'd144, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{KEY_FREEZE,    8'd144, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{KEY_MODE,      8'd144, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{KEY_DEFAULTS,  8'd128, 2'd0, 1'b0, 1'b1, 1'b0};

    rst_n       = 1'b0;
    key_valid   = 1'b0;
    key_code    = 8'h00;
    capture_ack = 1'b0;
    idle(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    idle(2);

    // Table: every key is spaced well beyond the lockout window.
    for (int i = 0; i < 13; i++) begin
      pulse(vecs[i].code);
      check($sformatf("vec%0d_bright", i), brightness, vecs[i].bright);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].mode);
      check($sformatf("vec%0d_freeze", i), freeze, vecs[i].frz);
      check($sformatf("vec%0d_done", i), cmd_done, vecs[i].done);
      check($sformatf("vec%0d_drop", i), cmd_drop, vecs[i].drop);
      check($sformatf("vec%0d_req", i), capture_req, 0);
      idle(1);
      check($sformatf("vec%0d_pulse_clr", i), {30'd0, cmd_done, cmd_drop}, 0);
      idle(110);
    end

    // Upper saturation: 128 + 15*8 = 248, then 255 and stays.
    for (int i = 0; i < 15; i++) begin
      pulse(KEY_BRIGHT_UP);
      idle(110);
    end
    check("sat_248", brightness, 248);
    pulse(KEY_BRIGHT_UP);
    check("sat_up_255", brightness, 255);
    idle(110);
    pulse(KEY_BRIGHT_UP);
    check("sat_up_hold", brightness, 255);
    check("sat_up_hold_done", cmd_done, 1);
    idle(110);

    // Lower saturation: 255 - 31*8 = 7, then 0 and stays.
    for (int i = 0; i < 31; i++) begin
      pulse(KEY_BRIGHT_DN);
      idle(110);
    end
    check("sat_7", brightness, 7);
    pulse(KEY_BRIGHT_DN);
    check("sat_dn_0", brightness, 0);
    idle(110);
    pulse(KEY_BRIGHT_DN);
    check("sat_dn_hold", brightness, 0);
    check("sat_dn_hold_done", cmd_done, 1);
    idle(110);

    // Lockout: repeats 10 cycles apart are ignored; 100 after last still locked, 101 opens.
    pulse(KEY_MODE);
    check("lock_first_mode", mode, 1);
    check("lock_first_done", cmd_done, 1);
    for (int i = 0; i < 3; i++) begin
      idle(8);
      pulse(KEY_MODE);
      check($sformatf("lock_rep%0d_mode", i), mode, 1);
      check($sformatf("lock_rep%0d_pulses", i), {30'd0, cmd_done, cmd_drop}, 0);
    end
    idle(98);
    pulse(KEY_MODE);
    check("lock_gap100_mode", mode, 1);
    check("lock_gap100_done", cmd_done, 0);
    idle(99);
    pulse(KEY_MODE);
    check("lock_gap101_mode", mode, 2);
    check("lock_gap101_done", cmd_done, 1);
    idle(110);
    pulse(KEY_MODE);
    check("lock_wrap_mode", mode, 0);
    idle(110);

    // Back-to-back key_valid cycles.
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = KEY_BRIGHT_UP;
    @(posedge clk);
    #1;
    key_code = KEY_BRIGHT_DN;
    check("b2b_up_bright", brightness, 8);
    check("b2b_up_done", cmd_done, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check("b2b_dn_bright", brightness, 0);
    check("b2b_dn_done", cmd_done, 1);
    idle(110);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code  = KEY_FREEZE;
    @(posedge clk);
    #1;
    check("b2b_frz1", freeze, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check("b2b_frz_same_freeze", freeze, 1);
    check("b2b_frz_same_pulses", {30'd0, cmd_done, cmd_drop}, 0);
    idle(110);

    // Capture handshake.
    capture_ack = 1'b1;
    idle(5);
    check("ack_idle_req", capture_req, 0);
    capture_ack = 1'b0;
    idle(2);
    pulse(KEY_CAPTURE);
    check("cap_req", capture_req, 1);
    check("cap_done", cmd_done, 1);
    idle(5);
    check("cap_req_hold", capture_req, 1);
    pulse(8'h55);
    check("cap_gap_drop", cmd_drop, 1);
    idle(3);
    pulse(KEY_CAPTURE);
    check("cap_busy_drop", cmd_drop, 1);
    check("cap_busy_done", cmd_done, 0);
    check("cap_busy_req", capture_req, 1);
    capture_ack = 1'b1;
    idle(1);
    check("cap_ack_req", capture_req, 0);
    idle(110);
    pulse(KEY_CAPTURE);
    check("cap_waitlow_drop", cmd_drop, 1);
    check("cap_waitlow_req", capture_req, 0);
    capture_ack = 1'b0;
    idle(110);
    pulse(KEY_CAPTURE);
    check("cap_again_done", cmd_done, 1);
    check("cap_again_req", capture_req, 1);
    idle(3);

    // Asynchronous reset in mid-handshake, well before the next edge.
    rst_n = 1'b0;
    #2;
    check("arst_req", capture_req, 0);
    check("arst_bright", brightness, 128);
    check("arst_freeze", freeze, 0);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check_reset_vals("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
